vga_layer_compositor: RTL

Parametrised pixel compositor replacing the hard-wired R/G/B expressions in the top level. Draws NUM_PIPES gap-pipes plus one bird sprite over a background, with fixed layer priority and a frame-counted flash mode for the lose state. Object coordinates are shadowed at frame start, so the picture never tears mid-frame. Also reports per-frame bird/pipe pixel overlap. Sits between the hsync/vsync counter generator and the registered VGA pins.

---
 rtl/vga_layer_compositor_pkg.sv | 36 +++
 rtl/vga_layer_compositor_pipe_hit_cell.sv | 61 ++++++
 rtl/vga_layer_compositor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_layer_compositor_pkg.sv
// vga_pkg: shared types and constants for the VGA layer compositor.
//   rgb332_t      - packed 8-bit RGB332 colour
//   rgb_pins_t    - colour split into the 3/3/2 pin fields
//   flash_state_t - lose-state flash FSM encoding
//   rgb_split()   - RGB332 -> {r,g,b} field split
package vga_pkg;

    typedef logic [7:0] rgb332_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_pins_t;

    localparam rgb332_t RGB_BLACK = 8'h00;
    localparam rgb332_t RGB_BIRD  = 8'hE0;
    localparam rgb332_t RGB_PIPE  = 8'h1C;
    localparam rgb332_t RGB_BG    = 8'h00;
    localparam rgb332_t RGB_FLASH = 8'h03;

    typedef enum logic [1:0] {
        FL_OFF   = 2'd0,
        FL_ON_HI = 2'd1,
        FL_ON_LO = 2'd2
    } flash_state_t;

    function automatic rgb_pins_t rgb_split(input rgb332_t c);
        rgb_pins_t p;
        p.r = c[7:5];
        p.g = c[4:2];
        p.b = c[1:0];
        return p;
    endfunction

endpackage

// File: rtl/vga_layer_compositor_pipe_hit_cell.sv
// pipe_hit_cell: one gap-pipe channel.
// Holds the per-frame shadow of the channel's bounds and enable, and
// produces a combinational hit for the current pixel.
//   board_clk, Reset  - clock, async active-high reset
//   cap_i             - capture strobe (pix_ce && frame_start)
//   x_i, y_i          - current pixel
//   xl_i..yb_i, en_i  - live channel bounds / enable
//   hit_o             - pixel lies on the drawn pipe body
module pipe_hit_cell
    import vga_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic          board_clk,
    input  logic          Reset,
    input  logic          cap_i,
    input  logic [CW-1:0] x_i,
    input  logic [CW-1:0] y_i,
    input  logic [CW-1:0] xl_i,
    input  logic [CW-1:0] xr_i,
    input  logic [CW-1:0] yt_i,
    input  logic [CW-1:0] yb_i,
    input  logic          en_i,
    output logic          hit_o
);

    logic [CW-1:0] xl_q, xr_q, yt_q, yb_q;
    logic          en_q;
    logic [CW-1:0] xl, xr, yt, yb;
    logic          en;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            xl_q <= '0;
            xr_q <= '0;
            yt_q <= '0;
            yb_q <= '0;
            en_q <= 1'b0;
        end else if (cap_i) begin
            xl_q <= xl_i;
            xr_q <= xr_i;
            yt_q <= yt_i;
            yb_q <= yb_i;
            en_q <= en_i;
        end
    end

    // On the capture beat the shadow is still stale; use the live values so
    // pixel (0,0) already sees the new frame's geometry.
    always_comb begin
        xl = cap_i ? xl_i : xl_q;
        xr = cap_i ? xr_i : xr_q;
        yt = cap_i ? yt_i : yt_q;
        yb = cap_i ? yb_i : yb_q;
        en = cap_i ? en_i : en_q;
    end

    // Drawn outside the gap: above (or on) its top edge, below (or on) its bottom edge.
    assign hit_o = en && (x_i >= xl) && (x_i <= xr) && ((y_i <= yt) || (y_i >= yb));

endmodule

// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: draws NUM_PIPES gap-pipes and a bird sprite over a
// background, with a frame-counted flash background for the lose state.
// Two pix_ce beats from counter inputs to the RGB pins.
//   board_clk, Reset       - clock, async active-high reset
//   pix_ce                 - pixel-rate enable
//   frame_start            - pulse at pixel (0,0), on a pix_ce beat
//   counter_x/y, in_display- current pixel and visible-area flag
//   bird_*                 - bird box, inclusive
//   pipe_xl/xr/yt/yb, en   - per-channel pipe geometry, channel i at [i*CW +: CW]
//   flash_req              - lose-state flash request (sampled at frame start)
//   vga_r/g/b              - registered colour
//   frame_collide          - bird touched a drawn pipe pixel in the previous frame
//   flash_phase            - flash background select
module vga_layer_compositor
    import vga_pkg::*;
#(
    parameter int      NUM_PIPES    = 5,
    parameter int      CW           = 10,
    parameter int      FLASH_FRAMES = 8,
    parameter rgb332_t BIRD_RGB     = RGB_BIRD,
    parameter rgb332_t PIPE_RGB     = RGB_PIPE,
    parameter rgb332_t BG_RGB       = RGB_BG,
    parameter rgb332_t FLASH_RGB    = RGB_FLASH
) (
    input  logic                    board_clk,
    input  logic                    Reset,
    input  logic                    pix_ce,
    input  logic                    frame_start,
    input  logic [CW-1:0]           counter_x,
    input  logic [CW-1:0]           counter_y,
    input  logic                    in_display,
    input  logic [CW-1:0]           bird_xl,
    input  logic [CW-1:0]           bird_xr,
    input  logic [CW-1:0]           bird_yt,
    input  logic [CW-1:0]           bird_yb,
    input  logic [NUM_PIPES*CW-1:0] pipe_xl,
    input  logic [NUM_PIPES*CW-1:0] pipe_xr,
    input  logic [NUM_PIPES*CW-1:0] pipe_yt,
    input  logic [NUM_PIPES*CW-1:0] pipe_yb,
    input  logic [NUM_PIPES-1:0]    pipe_en,
    input  logic                    flash_req,
    output logic [2:0]              vga_r,
    output logic [2:0]              vga_g,
    output logic [1:0]              vga_b,
    output logic                    frame_collide,
    output logic                    flash_phase
);

    localparam int FW = $clog2(FLASH_FRAMES) + 1;
    localparam logic [FW-1:0] FC_LAST = FW'(FLASH_FRAMES - 1);

    logic cap;
    assign cap = pix_ce && frame_start;

    // ---------------- bird shadow + hit ----------------
    logic [CW-1:0] bxl_q, bxr_q, byt_q, byb_q;
    logic [CW-1:0] bxl, bxr, byt, byb;
    logic          bird_hit;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            bxl_q <= '0;
            bxr_q <= '0;
            byt_q <= '0;
            byb_q <= '0;
        end else if (cap) begin
            bxl_q <= bird_xl;
            bxr_q <= bird_xr;
            byt_q <= bird_yt;
            byb_q <= bird_yb;
        end
    end

    always_comb begin
        bxl = cap ? bird_xl : bxl_q;
        bxr = cap ? bird_xr : bxr_q;
        byt = cap ? bird_yt : byt_q;
        byb = cap ? bird_yb : byb_q;
    end

    // An inverted box fails one of the pairs and so draws nothing.
    assign bird_hit = (counter_x >= bxl) && (counter_x <= bxr) &&
                      (counter_y >= byt) && (counter_y <= byb);

    // ---------------- pipe channels ----------------
    logic [NUM_PIPES-1:0] pipe_hit;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        pipe_hit_cell #(.CW(CW)) u_cell (
            .board_clk (board_clk),
            .Reset     (Reset),
            .cap_i     (cap),
            .x_i       (counter_x),
            .y_i       (counter_y),
            .xl_i      (pipe_xl[i*CW +: CW]),
            .xr_i      (pipe_xr[i*CW +: CW]),
            .yt_i      (pipe_yt[i*CW +: CW]),
            .yb_i      (pipe_yb[i*CW +: CW]),
            .en_i      (pipe_en[i]),
            .hit_o     (pipe_hit[i])
        );
    end

    // ---------------- stage 1 ----------------
    logic bird_hit_s1_q, pipe_any_s1_q, disp_s1_q, fs_s1_q;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            bird_hit_s1_q <= 1'b0;
            pipe_any_s1_q <= 1'b0;
            disp_s1_q     <= 1'b0;
            fs_s1_q       <= 1'b0;
        end else if (pix_ce) begin
            bird_hit_s1_q <= bird_hit;
            pipe_any_s1_q <= |pipe_hit;
            disp_s1_q     <= in_display;
            fs_s1_q       <= frame_start;
        end
    end

    // ---------------- stage 2: colour ----------------
    rgb332_t   colour_d, colour_q;
    rgb_pins_t pins;

    always_comb begin
        colour_d = RGB_BLACK;
        if (!disp_s1_q)         colour_d = RGB_BLACK;
        else if (bird_hit_s1_q) colour_d = BIRD_RGB;
        else if (pipe_any_s1_q) colour_d = PIPE_RGB;
        else                    colour_d = flash_phase ? FLASH_RGB : BG_RGB;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset)       colour_q <= RGB_BLACK;
        else if (pix_ce) colour_q <= colour_d;
    end

    assign pins  = rgb_split(colour_q);
    assign vga_r = pins.r;
    assign vga_g = pins.g;
    assign vga_b = pins.b;

    // ---------------- per-frame overlap ----------------
    // The frame_start pixel belongs to the new frame, so it seeds the
    // accumulator while the finished frame's result is published.
    logic ov_s1, acc_q, collide_q;
    assign ov_s1 = bird_hit_s1_q && pipe_any_s1_q && disp_s1_q;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            acc_q     <= 1'b0;
            collide_q <= 1'b0;
        end else if (pix_ce) begin
            if (fs_s1_q) begin
                collide_q <= acc_q;
                acc_q     <= ov_s1;
            end else begin
                acc_q <= acc_q | ov_s1;
            end
        end
    end

    assign frame_collide = collide_q;

    // ---------------- flash FSM ----------------
    flash_state_t  state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= FL_OFF;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // flash_req is only looked at on frame_start beats.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (cap) begin
            if (!flash_req) begin
                state_d = FL_OFF;
                fcnt_d  = '0;
            end else begin
                case (state_q)
                    FL_OFF: begin
                        state_d = FL_ON_HI;
                        fcnt_d  = '0;
                    end
                    FL_ON_HI, FL_ON_LO: begin
                        if (fcnt_q == FC_LAST) begin
                            state_d = (state_q == FL_ON_HI) ? FL_ON_LO : FL_ON_HI;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = FL_OFF;
                        fcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        flash_phase = (state_q == FL_ON_HI);
    end

endmodule
